// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, state and datapath-select encodings for the multi-cycle control unit
package cpu_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_RTYPE  = 7'b0110011,
        OP_BRANCH = 7'b1100011,
        OP_IALU   = 7'b0010011
    } opcode_t;

    typedef enum logic [3:0] {
        RESET_S  = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMREAD  = 4'd4,
        MEMWB    = 4'd5,
        MEMWRITE = 4'd6,
        EXEC_R   = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        EXEC_I   = 4'd10,
        TRAP     = 4'd11
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'b00,
        SRC_A_OLD_PC = 2'b01,
        SRC_A_RS1    = 2'b10
    } src_a_t;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } src_b_t;

    typedef enum logic [1:0] {
        RES_ALU_OUT    = 2'b00,
        RES_MEM_DATA   = 2'b01,
        RES_ALU_DIRECT = 2'b10
    } result_src_t;

    // fetch marks the state in which a ready memory beat loads IR and advances PC
    typedef struct packed {
        logic        fetch;
        logic        adr_src;
        logic        mem_read;
        logic        mem_write;
        src_a_t      alu_src_a;
        src_b_t      alu_src_b;
        alu_op_t     alu_op;
        result_src_t result_src;
        logic        reg_write;
        logic        branch;
        logic        trap;
    } ctrl_out_t;

    function automatic ctrl_out_t ctrl_decode(ctrl_state_t s);
        ctrl_out_t o;
        o = '0;
        case (s)
            FETCH: begin
                o.fetch      = 1'b1;
                o.mem_read   = 1'b1;
                o.alu_src_a  = SRC_A_PC;
                o.alu_src_b  = SRC_B_FOUR;
                o.alu_op     = ALU_ADD;
                o.result_src = RES_ALU_DIRECT;
            end
            DECODE: begin
                o.alu_src_a = SRC_A_OLD_PC;
                o.alu_src_b = SRC_B_IMM;
                o.alu_op    = ALU_ADD;
            end
            MEMADR: begin
                o.alu_src_a = SRC_A_RS1;
                o.alu_src_b = SRC_B_IMM;
                o.alu_op    = ALU_ADD;
            end
            MEMREAD: begin
                o.mem_read = 1'b1;
                o.adr_src  = 1'b1;
            end
            MEMWB: begin
                o.result_src = RES_MEM_DATA;
                o.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                o.mem_write = 1'b1;
                o.adr_src   = 1'b1;
            end
            EXEC_R: begin
                o.alu_src_a = SRC_A_RS1;
                o.alu_src_b = SRC_B_RS2;
                o.alu_op    = ALU_FUNCT;
            end
            EXEC_I: begin
                o.alu_src_a = SRC_A_RS1;
                o.alu_src_b = SRC_B_IMM;
                o.alu_op    = ALU_FUNCT;
            end
            ALUWB: begin
                o.result_src = RES_ALU_OUT;
                o.reg_write  = 1'b1;
            end
            BRANCH: begin
                o.alu_src_a  = SRC_A_RS1;
                o.alu_src_b  = SRC_B_RS2;
                o.alu_op     = ALU_SUB;
                o.branch     = 1'b1;
                o.result_src = RES_ALU_OUT;
            end
            TRAP: o.trap = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// rtl/ctrl_wait_timer.sv - saturating memory wait counter that flags when the wait budget is used up
module ctrl_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TIMER_W     = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(MEM_TIMEOUT);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + TIMER_W'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle control FSM; CTRL_IMM_ALU_EN adds the EXEC_I immediate-ALU path
module multicycle_controller
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TIMER_W     = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       reg_write,
    output logic       trap,
    output logic [3:0] state_o
);

    ctrl_state_t state;
    ctrl_state_t state_next;
    ctrl_out_t   outs;
    logic        op_store;
    logic        wait_state;
    logic        timer_clear;
    logic        timer_inc;
    logic        timer_expired;
    logic        pc_write;

    assign wait_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);

    always_comb begin
        state_next = state;
        case (state)
            RESET_S: state_next = FETCH;
            FETCH: begin
                if (mem_ready)          state_next = DECODE;
                else if (timer_expired) state_next = TRAP;
            end
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_RTYPE:          state_next = EXEC_R;
                    OP_BRANCH:         state_next = BRANCH;
`ifdef CTRL_IMM_ALU_EN
                    OP_IALU:           state_next = EXEC_I;
`endif
                    default:           state_next = TRAP;
                endcase
            end
            MEMADR: state_next = op_store ? MEMWRITE : MEMREAD;
            MEMREAD: begin
                if (mem_ready)          state_next = MEMWB;
                else if (timer_expired) state_next = TRAP;
            end
            MEMWB: state_next = FETCH;
            MEMWRITE: begin
                if (mem_ready)          state_next = FETCH;
                else if (timer_expired) state_next = TRAP;
            end
            EXEC_R: state_next = ALUWB;
`ifdef CTRL_IMM_ALU_EN
            EXEC_I: state_next = ALUWB;
`endif
            ALUWB:  state_next = FETCH;
            BRANCH: state_next = FETCH;
            TRAP:   state_next = TRAP;
            default: state_next = TRAP;
        endcase
    end

    // Every transition clears the counter, so it always starts at 0 on entry to a wait state.
    assign timer_clear = (state_next != state);
    assign timer_inc   = wait_state && !mem_ready;

    ctrl_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TIMER_W     (TIMER_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .inc     (timer_inc),
        .expired (timer_expired)
    );

    // Outputs are registered from the next state, so they always equal the decode of the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RESET_S;
            outs     <= '0;
            op_store <= 1'b0;
        end else begin
            state <= state_next;
            outs  <= ctrl_decode(state_next);
            if (state == DECODE) begin
                op_store <= (opcode == OP_STORE);
            end
        end
    end

    // IR load and PC advance happen only on the beat where fetch data is actually valid.
    assign pc_write   = outs.fetch & mem_ready;
    assign ir_write   = outs.fetch & mem_ready;
    assign pc_en      = pc_write | (outs.branch & zero);
    assign adr_src    = outs.adr_src;
    assign mem_read   = outs.mem_read;
    assign mem_write  = outs.mem_write;
    assign alu_src_a  = outs.alu_src_a;
    assign alu_src_b  = outs.alu_src_b;
    assign alu_op     = outs.alu_op;
    assign result_src = outs.result_src;
    assign reg_write  = outs.reg_write;
    assign trap       = outs.trap;
    assign state_o    = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - trace-model bench for multicycle_controller (honours CTRL_IMM_ALU_EN)
module tb_multicycle_controller;
    import cpu_pkg::*;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, ir_write, adr_src, mem_read, mem_write, reg_write, trap;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .ir_write   (ir_write),
        .adr_src    (adr_src),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .reg_write  (reg_write),
        .trap       (trap),
        .state_o    (state_o)
    );

    // {pc_en, ir_write, adr_src, mem_read, mem_write, src_a, src_b, alu_op, result_src, reg_write, trap}
    logic [14:0] obs;
    assign obs = {pc_en, ir_write, adr_src, mem_read, mem_write, alu_src_a, alu_src_b,
                  alu_op, result_src, reg_write, trap};

    localparam logic [14:0] O_ZERO   = 15'd0;
    localparam logic [14:0] O_FETCH  = {5'b00010, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0};
    localparam logic [14:0] O_FPULSE = {5'b11000, 10'd0};
    localparam logic [14:0] O_DECODE = {5'b00000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] O_MEMADR = {5'b00000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] O_MEMRD  = {5'b00110, 10'd0};
    localparam logic [14:0] O_MEMWB  = {5'b00000, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0};
    localparam logic [14:0] O_MEMWR  = {5'b00101, 10'd0};
    localparam logic [14:0] O_EXECR  = {5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] O_EXECI  = {5'b00000, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] O_ALUWB  = {5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [14:0] O_BRANCH = {5'b00000, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] O_TRAP   = 15'd1;

    typedef struct {
        ctrl_state_t st;
        bit          rdy;
        bit          z;
        logic [14:0] o;
    } step_t;

    step_t plan[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    localparam int K_LOAD = 0, K_STORE = 1, K_RTYPE = 2, K_BRANCH = 3, K_IALU = 4, K_ILLEGAL = 5;

    task automatic add(input ctrl_state_t st, input bit rdy, input bit z, input logic [14:0] o);
        step_t s;
        s.st = st; s.rdy = rdy; s.z = z; s.o = o;
        plan.push_back(s);
    endtask

    // A memory phase: 'waits' not-ready cycles then the ready beat; more than TMO waits times out.
    task automatic mem_phase(input ctrl_state_t st, input logic [14:0] o, input int waits,
                             output bit timed_out);
        timed_out = (waits > TMO);
        for (int i = 0; i < (timed_out ? TMO + 1 : waits); i++)
            add(st, 1'b0, 1'($urandom), o);
        if (!timed_out)
            add(st, 1'b1, 1'($urandom), (st == FETCH) ? (o | O_FPULSE) : o);
    endtask

    task automatic add_trap(input int n);
        for (int i = 0; i < n; i++) add(TRAP, 1'($urandom), 1'($urandom), O_TRAP);
    endtask

    task automatic gen_instr(input int kind, input int fw, input int mw, input bit z,
                             output bit trapped);
        bit to;
        trapped = 1'b0;
        mem_phase(FETCH, O_FETCH, fw, to);
        if (to) begin add_trap(3); trapped = 1'b1; return; end
        add(DECODE, 1'($urandom), 1'($urandom), O_DECODE);
        case (kind)
            K_LOAD: begin
                add(MEMADR, 1'($urandom), 1'($urandom), O_MEMADR);
                mem_phase(MEMREAD, O_MEMRD, mw, to);
                if (to) begin add_trap(3); trapped = 1'b1; end
                else add(MEMWB, 1'($urandom), 1'($urandom), O_MEMWB);
            end
            K_STORE: begin
                add(MEMADR, 1'($urandom), 1'($urandom), O_MEMADR);
                mem_phase(MEMWRITE, O_MEMWR, mw, to);
                if (to) begin add_trap(3); trapped = 1'b1; end
            end
            K_RTYPE: begin
                add(EXEC_R, 1'($urandom), 1'($urandom), O_EXECR);
                add(ALUWB, 1'($urandom), 1'($urandom), O_ALUWB);
            end
            K_BRANCH: add(BRANCH, 1'($urandom), z, O_BRANCH | {z, 14'd0});
            K_IALU: begin
`ifdef CTRL_IMM_ALU_EN
                add(EXEC_I, 1'($urandom), 1'($urandom), O_EXECI);
                add(ALUWB, 1'($urandom), 1'($urandom), O_ALUWB);
`else
                add_trap(3); trapped = 1'b1;
`endif
            end
            default: begin add_trap(20); trapped = 1'b1; end
        endcase
    endtask

    task automatic run_plan();
        step_t e;
        while (plan.size() > 0) begin
            e = plan.pop_front();
            @(negedge clk);
            mem_ready = e.rdy;
            zero = e.z;
            #1;
            cyc++;
            checks++;
            assert (state_o === 4'(e.st)) else begin
                errors++;
                $error("FAIL state cyc=%0d observed=%0d expected=%0d", cyc, state_o, 4'(e.st));
            end
            checks++;
            assert (obs === e.o) else begin
                errors++;
                $error("FAIL outputs cyc=%0d state=%0d observed=%b expected=%b", cyc, 4'(e.st), obs, e.o);
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        assert (state_o === 4'(RESET_S)) else begin
            errors++;
            $error("FAIL %s_state observed=%0d expected=%0d", tag, state_o, 4'(RESET_S));
        end
        checks++;
        assert (obs === O_ZERO) else begin
            errors++;
            $error("FAIL %s_outputs observed=%b expected=%b", tag, obs, O_ZERO);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        zero = 1'b1;
        #1;
        check_reset_state("reset_assert");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_state("reset_release");
    endtask

    function automatic logic [6:0] kind_opcode(input int kind);
        logic [6:0] op;
        case (kind)
            K_LOAD:   op = 7'b0000011;
            K_STORE:  op = 7'b0100011;
            K_RTYPE:  op = 7'b0110011;
            K_BRANCH: op = 7'b1100011;
            K_IALU:   op = 7'b0010011;
            default: begin
                do op = 7'($urandom);
                while (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
                       op == 7'b1100011 || op == 7'b0010011);
            end
        endcase
        return op;
    endfunction

    task automatic do_instr(input int kind, input int fw, input int mw, input bit z,
                            input logic [6:0] op);
        bit trapped;
        opcode = op;
        gen_instr(kind, fw, mw, z, trapped);
        run_plan();
        if (trapped) do_reset();
    endtask

    initial begin
        bit to;
        do_reset();

        // R-type with zero-wait memory, then load with three MEMREAD waits
        do_instr(K_RTYPE, 0, 0, 1'b0, 7'b0110011);
        do_instr(K_LOAD, 0, 3, 1'b0, 7'b0000011);
        do_instr(K_STORE, 0, 0, 1'b0, 7'b0100011);
        do_instr(K_BRANCH, 0, 0, 1'b1, 7'b1100011);
        do_instr(K_BRANCH, 0, 0, 1'b0, 7'b1100011);

        // Unsupported opcode holds TRAP for 20 cycles, then reset
        do_instr(K_ILLEGAL, 0, 0, 1'b0, 7'b1111111);

        // Fetch timeout, and ready arriving exactly at the limit
        do_instr(K_RTYPE, TMO + 1, 0, 1'b0, 7'b0110011);
        do_instr(K_RTYPE, TMO, 0, 1'b0, 7'b0110011);
        do_instr(K_STORE, 1, TMO + 1, 1'b0, 7'b0100011);
        do_instr(K_LOAD, 2, TMO, 1'b0, 7'b0000011);
        do_instr(K_IALU, 0, 0, 1'b0, 7'b0010011);

        // Reset asserted while a read is outstanding drops the request at once
        opcode = 7'b0000011;
        mem_phase(FETCH, O_FETCH, 0, to);
        add(DECODE, 1'b0, 1'b0, O_DECODE);
        add(MEMADR, 1'b0, 1'b0, O_MEMADR);
        add(MEMREAD, 1'b0, 1'b0, O_MEMRD);
        add(MEMREAD, 1'b0, 1'b0, O_MEMRD);
        run_plan();
        do_reset();

        for (int n = 0; n < 60; n++) begin
            int kind;
            int fw;
            int mw;
            kind = ($urandom_range(0, 15) == 0) ? K_ILLEGAL : int'($urandom_range(0, 4));
            fw = ($urandom_range(0, 9) == 0) ? TMO + 1 : int'($urandom_range(0, TMO));
            mw = ($urandom_range(0, 9) == 0) ? TMO + 1 : int'($urandom_range(0, TMO));
            do_instr(kind, fw, mw, 1'($urandom), kind_opcode(kind));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle successor to the single-cycle control decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states and drives the datapath's register enables and mux selects one state at a time. It stalls on a ready/valid-style memory handshake and traps on unsupported opcodes or memory timeout. It sits between the instruction register/flags and the shared multi-cycle datapath.

## Interface
- `MEM_TIMEOUT`, default 16: maximum cycles spent waiting for `mem_ready` in any memory state before trapping; minimum 1.
- `TIMER_W`, default `$clog2(MEM_TIMEOUT+1)`: wait-counter width.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `opcode` in 7: `instr[6:0]` from the instruction register; sampled in DECODE.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory accepted the write, or has read data valid, this cycle.
- `pc_en` out 1: PC register enable; equals `pc_write | (branch & zero)`.
- `ir_write` out 1: instruction register load.
- `adr_src` out 1: 0 = PC, 1 = ALU result register.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `alu_src_a` out 2: 00 PC, 01 old PC, 10 rs1.
- `alu_src_b` out 2: 00 rs2, 01 immediate, 10 constant 4.
- `alu_op` out 2: 00 add, 01 subtract/compare, 10 funct-decoded.
- `result_src` out 2: 00 ALU result register, 01 memory data, 10 ALU direct.
- `reg_write` out 1: register file write.
- `trap` out 1: sticky fault indicator.
- `state_o` out 4: current state, for debug and bench.

## Operation
- States: RESET_S, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, ALUWB, BRANCH, EXEC_I (macro only), TRAP.
- RESET_S → FETCH on the first clock after reset release.
- FETCH:
  - Asserts `mem_read`, `adr_src=0`, `alu_src_a=00`, `alu_src_b=10`, `alu_op=00`, `result_src=10`.
  - Holds until `mem_ready=1`. In the ready cycle it pulses `ir_write` and `pc_write` and moves to DECODE.
- DECODE:
  - Drives `alu_src_a=01`, `alu_src_b=01`, `alu_op=00` to precompute the branch target.
  - Next state by opcode:
    - load `0000011` or store `0100011` → MEMADR
    - R-type `0110011` → EXEC_R
    - branch `1100011` → BRANCH
    - I-ALU `0010011` → EXEC_I (macro only)
    - anything else → TRAP
- MEMADR: `alu_src_a=10`, `alu_src_b=01`, `alu_op=00`. Goes to MEMREAD for a load, MEMWRITE for a store; the opcode is latched in DECODE.
- MEMREAD: `mem_read=1`, `adr_src=1`. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `result_src=01`, `reg_write=1` → FETCH.
- MEMWRITE: `mem_write=1`, `adr_src=1`. Holds until `mem_ready`, then goes to FETCH.
- EXEC_R: `alu_src_a=10`, `alu_src_b=00`, `alu_op=10` → ALUWB.
- ALUWB: `result_src=00`, `reg_write=1` → FETCH.
- BRANCH:
  - `alu_src_a=10`, `alu_src_b=00`, `alu_op=01`, `branch=1`, `result_src=00` → FETCH.
  - `pc_en` follows `zero` in this state.
- TRAP: all enables 0 and `trap=1`. Left only by reset.
- Wait counter:
  - Clears on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments each cycle `mem_ready=0` in those states.
  - When it reaches `MEM_TIMEOUT` with `mem_ready` still 0, the next state is TRAP.
  - `mem_ready=1` in the same cycle the count reaches the limit completes normally; ready wins.
- Outputs are Moore, decoded from registered state only, except `pc_en`, which also uses `zero`.

## Timing
- Reset values: state RESET_S and counter 0. Every output is 0 except `state_o`, which shows the RESET_S encoding.
- Reset assertion mid-instruction returns to RESET_S immediately. An in-flight memory request drops the same cycle.
- Cycles per instruction with zero-wait memory (`mem_ready` high on first request cycle):
  - load 5
  - store 4
  - R-type 4
  - branch 3
  - I-ALU 4
- Each wait cycle adds 1 to the FETCH, MEMREAD or MEMWRITE count.
- `mem_read`/`mem_write` stay stable and asserted every cycle until the `mem_ready` cycle. They deassert on the following cycle.
- `ir_write` and `pc_write` are single-cycle pulses per fetch.

## Configuration
- `CTRL_IMM_ALU_EN` defined:
  - Opcode `0010011` decodes to EXEC_I.
  - EXEC_I drives `alu_src_a=10`, `alu_src_b=01`, `alu_op=10`, then goes to ALUWB.
- Undefined: EXEC_I is absent and `0010011` traps like any unsupported opcode.

## Structure
- Shared `cpu_pkg` holds:
  - `opcode_t` enum, with the R-type, load, store, branch and I-ALU encodings above.
  - `ctrl_state_t` enum, 4-bit.
  - `alu_op_t`, `src_a_t`, `src_b_t`, `result_src_t` localparam/enum encodings.
- One sub-module, `ctrl_wait_timer`: the wait counter with `clear`/`inc` inputs and a `expired` output, parameterised on `MEM_TIMEOUT`.

## Test plan
- Reset, then R-type `0110011` with `mem_ready` tied high → states FETCH, DECODE, EXEC_R, ALUWB, FETCH; `reg_write=1` only in cycle 4; `ir_write` pulses once.
- Load with `mem_ready` low for 3 cycles in MEMREAD → MEMREAD held 4 cycles with `mem_read=1`, `adr_src=1`; MEMWB then asserts `result_src=01`, `reg_write=1`.
- Branch with `zero=1`, then with `zero=0` → `pc_en=1` in BRANCH for the first, `pc_en=0` in BRANCH for the second; both return to FETCH.
- Opcode `1111111` → TRAP after DECODE; `trap=1` held for 20 cycles; `rst_n` pulse returns to RESET_S with all outputs 0.
- `MEM_TIMEOUT=4`, `mem_ready` held low in FETCH → TRAP entered after 4 wait cycles. The same run with `mem_ready` rising exactly at count 4 → DECODE.
- `0010011` with `CTRL_IMM_ALU_EN` defined → EXEC_I, then ALUWB. The same opcode with the macro undefined → TRAP.
